// File: rtl/gte_bridge_pkg.sv
// Shared types for the GTE COP2 bridge: request kinds, FSM states, engine register IDs.
package gte_bridge_pkg;

    typedef enum logic [2:0] {
        KIND_MTC2 = 3'd0,
        KIND_CTC2 = 3'd1,
        KIND_MFC2 = 3'd2,
        KIND_CFC2 = 3'd3,
        KIND_CMD  = 3'd4
    } E_COP2KIND;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } E_BRIDGE_ST;

    typedef logic [5:0] E_REG;

    // Control registers live in the upper half of the engine register map.
    localparam int CTRL_BANK_BIT = 5;

    function automatic E_REG mapRegID(input E_COP2KIND kind, input logic [4:0] regNum);
        E_REG id;
        id = {1'b0, regNum};
        id[CTRL_BANK_BIT] = (kind == KIND_CTC2) || (kind == KIND_CFC2);
        return id;
    endfunction

endpackage

// File: rtl/gte_cop2_bridge_if.sv
// CPU coprocessor port plus GTE engine register/instruction port, bundled for the bridge.
interface gte_cop2_bridge_if;
    logic                   i_reqValid;
    logic                   o_reqReady;
    logic [2:0]             i_reqKind;
    logic [4:0]             i_reqReg;
    logic [31:0]            i_reqData;
    logic [24:0]            i_reqCmd;
    logic                   o_rspValid;
    logic                   i_rspReady;
    logic [31:0]            o_rspData;
    gte_bridge_pkg::E_REG   o_regID;
    logic                   o_WritReg;
    logic                   o_ReadReg;
    logic [31:0]            o_dataIn;
    logic [31:0]            i_dataOut;
    logic [24:0]            o_Instruction;
    logic                   o_run;
    logic                   i_operationForbidden;

    modport master (
        input  i_reqValid, i_reqKind, i_reqReg, i_reqData, i_reqCmd, i_rspReady,
               i_dataOut, i_operationForbidden,
        output o_reqReady, o_rspValid, o_rspData, o_regID, o_WritReg, o_ReadReg,
               o_dataIn, o_Instruction, o_run
    );

    modport slave (
        output i_reqValid, i_reqKind, i_reqReg, i_reqData, i_reqCmd, i_rspReady,
               i_dataOut, i_operationForbidden,
        input  o_reqReady, o_rspValid, o_rspData, o_regID, o_WritReg, o_ReadReg,
               o_dataIn, o_Instruction, o_run
    );
endinterface

// File: rtl/gte_bridge_rspbuf.sv
// One-entry read-data holding register; loads in one cycle, valid holds until i_ready.
module gte_bridge_rspbuf (
    input  logic        i_clk,
    input  logic        i_nRst,
    input  logic        i_load,
    input  logic [31:0] i_loadData,
    input  logic        i_ready,
    output logic        o_valid,
    output logic [31:0] o_data
);

    always_ff @(posedge i_clk) begin
        if (!i_nRst) begin
            o_valid <= 1'b0;
            o_data  <= '0;
        end else if (i_load) begin
            o_valid <= 1'b1;
            o_data  <= i_loadData;
        end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/gte_cop2_bridge.sv
// CPU COP2 request -> GTE engine strobe bridge; strobe 1 cycle after accept, read data 2 cycles.
// Stalls in ISSUE while the engine is busy; no new accept while a response is pending.
module gte_cop2_bridge
    import gte_bridge_pkg::*;
#(
    parameter int STALL_CNT_W = 16,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                   i_clk,
    input  logic                   i_nRst,
    gte_cop2_bridge_if.master      bus,
    output logic [STALL_CNT_W-1:0] o_stallCycles,
    output logic                   o_timeoutErr
);

    E_BRIDGE_ST  state, stateNext;
    E_COP2KIND   holdKind;
    logic [4:0]  holdReg;
    logic [31:0] holdData;
    logic [24:0] holdCmd;
    logic [15:0] waitCnt;
    E_REG        lastRegID;
    logic [31:0] lastDataIn;
    logic [24:0] lastInstr;
    E_REG        issueID;
    logic        reqReady, accept, reserved, rspValid;
    logic        writStb, readStb, runStb;

    assign reserved = bus.i_reqKind > 3'd4;
    assign reqReady = i_nRst && (state == IDLE) && !rspValid;
    assign accept   = bus.i_reqValid && reqReady;
    assign issueID  = mapRegID(holdKind, holdReg);

    always_comb begin
        stateNext = state;
        writStb   = 1'b0;
        readStb   = 1'b0;
        runStb    = 1'b0;
        case (state)
            IDLE: begin
                if (accept && !reserved) stateNext = ISSUE;
            end
            ISSUE: begin
                if (!bus.i_operationForbidden) begin
                    stateNext = IDLE;
                    case (holdKind)
                        KIND_MTC2, KIND_CTC2: writStb = i_nRst;
                        KIND_MFC2, KIND_CFC2: readStb = i_nRst;
                        KIND_CMD:             runStb  = i_nRst;
                        default: ;
                    endcase
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign bus.o_reqReady    = reqReady;
    assign bus.o_WritReg     = writStb;
    assign bus.o_ReadReg     = readStb;
    assign bus.o_run         = runStb;
    assign bus.o_rspValid    = rspValid;
    assign bus.o_regID       = (writStb || readStb) ? issueID : lastRegID;
    assign bus.o_dataIn      = writStb ? holdData : lastDataIn;
    assign bus.o_Instruction = runStb ? holdCmd : lastInstr;

    always_ff @(posedge i_clk) begin
        if (!i_nRst) begin
            state         <= IDLE;
            holdKind      <= KIND_MTC2;
            holdReg       <= '0;
            holdData      <= '0;
            holdCmd       <= '0;
            waitCnt       <= '0;
            lastRegID     <= '0;
            lastDataIn    <= '0;
            lastInstr     <= '0;
            o_stallCycles <= '0;
            o_timeoutErr  <= 1'b0;
        end else begin
            state <= stateNext;
            if (accept) begin
                holdKind <= E_COP2KIND'(bus.i_reqKind);
                holdReg  <= bus.i_reqReg;
                holdData <= bus.i_reqData;
                holdCmd  <= bus.i_reqCmd;
            end
            // Wait counter parks at the threshold; the error flag is sticky until reset.
            if (state == ISSUE && bus.i_operationForbidden) begin
                if (o_stallCycles != '1) o_stallCycles <= o_stallCycles + STALL_CNT_W'(1);
                if (waitCnt != 16'(TIMEOUT_CYC)) waitCnt <= waitCnt + 16'd1;
                if (waitCnt == 16'(TIMEOUT_CYC - 1)) o_timeoutErr <= 1'b1;
            end else if (state == ISSUE) begin
                waitCnt <= '0;
            end
            if (writStb || readStb) lastRegID <= issueID;
            if (writStb) lastDataIn <= holdData;
            if (runStb) lastInstr <= holdCmd;
        end
    end

    gte_bridge_rspbuf u_rspbuf (
        .i_clk      (i_clk),
        .i_nRst     (i_nRst),
        .i_load     (readStb),
        .i_loadData (bus.i_dataOut),
        .i_ready    (bus.i_rspReady),
        .o_valid    (rspValid),
        .o_data     (bus.o_rspData)
    );

endmodule

// File: tb/tb_gte_cop2_bridge.sv
// Directed bench for gte_cop2_bridge: vector table for single requests plus hand-written stall/timeout/reset sequences.
module tb_gte_cop2_bridge;
    import gte_bridge_pkg::*;

    logic        clk  = 1'b0;
    logic        nRst = 1'b0;
    logic [15:0] stall;
    logic        terr;
    logic [3:0]  stall2;
    logic        terr2;
    int          nvec = 0;
    int          nerr = 0;

    gte_cop2_bridge_if bus ();
    gte_cop2_bridge_if sbus ();

    gte_cop2_bridge #(.STALL_CNT_W(16), .TIMEOUT_CYC(255)) u_dut (
        .i_clk(clk), .i_nRst(nRst), .bus(bus), .o_stallCycles(stall), .o_timeoutErr(terr)
    );

    gte_cop2_bridge #(.STALL_CNT_W(4), .TIMEOUT_CYC(10)) u_sat (
        .i_clk(clk), .i_nRst(nRst), .bus(sbus), .o_stallCycles(stall2), .o_timeoutErr(terr2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  kind;
        logic [4:0]  rg;
        logic [31:0] data;
        logic [24:0] cmd;
        logic [31:0] dout;
        logic [2:0]  stb;   // {wr, rd, run}
        logic [5:0]  id;
        logic        rsp;
    } vec_t;

    vec_t vt [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idleIn();
        bus.i_reqValid = 0; bus.i_reqKind = 0; bus.i_reqReg = 0; bus.i_reqData = 0;
        bus.i_reqCmd = 0; bus.i_rspReady = 0; bus.i_dataOut = 0; bus.i_operationForbidden = 0;
        sbus.i_reqValid = 0; sbus.i_reqKind = 0; sbus.i_reqReg = 0; sbus.i_reqData = 0;
        sbus.i_reqCmd = 0; sbus.i_rspReady = 0; sbus.i_dataOut = 0; sbus.i_operationForbidden = 0;
    endtask

    task automatic req(input logic [2:0] k, input logic [4:0] r, input logic [31:0] d, input logic [24:0] c);
        bus.i_reqValid = 1; bus.i_reqKind = k; bus.i_reqReg = r; bus.i_reqData = d; bus.i_reqCmd = c;
    endtask

    function automatic logic [31:0] strobes();
        return 32'({bus.o_WritReg, bus.o_ReadReg, bus.o_run});
    endfunction

    task automatic chkResetVals(input string nm);
        chk({nm, "_rspValid"}, 32'(bus.o_rspValid), 0);
        chk({nm, "_rspData"}, bus.o_rspData, 0);
        chk({nm, "_regID"}, 32'(bus.o_regID), 0);
        chk({nm, "_dataIn"}, bus.o_dataIn, 0);
        chk({nm, "_instr"}, 32'(bus.o_Instruction), 0);
        chk({nm, "_strobes"}, strobes(), 0);
        chk({nm, "_stall"}, 32'(stall), 0);
        chk({nm, "_terr"}, 32'(terr), 0);
        chk({nm, "_ready"}, 32'(bus.o_reqReady), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at 100us, required to finish");
        $fatal(1);
    end

    initial begin
        vt[0] = '{3'd0, 5'd9,  32'h0000_1234, 25'h0,       32'h0,         3'b100, 6'd9,  1'b0};
        vt[1] = '{3'd1, 5'd3,  32'hA5A5_0001, 25'h0,       32'h0,         3'b100, 6'd35, 1'b0};
        vt[2] = '{3'd2, 5'd14, 32'h0,         25'h0,       32'h0BAD_F00D, 3'b010, 6'd14, 1'b1};
        vt[3] = '{3'd3, 5'd31, 32'h0,         25'h0,       32'hDEAD_BEEF, 3'b010, 6'd63, 1'b1};
        vt[4] = '{3'd4, 5'd0,  32'h0,         25'h0000001, 32'h0,         3'b001, 6'd0,  1'b0};
        vt[5] = '{3'd6, 5'd4,  32'hFFFF_FFFF, 25'h1FFFFFF, 32'h0,         3'b000, 6'd0,  1'b0};
        vt[6] = '{3'd5, 5'd1,  32'h1,         25'h1,       32'h0,         3'b000, 6'd0,  1'b0};
        vt[7] = '{3'd4, 5'd0,  32'h0,         25'h1A2B3C4, 32'h0,         3'b001, 6'd0,  1'b0};

        idleIn();
        nRst = 0;
        smp();
        chk("rst_ready_low", 32'(bus.o_reqReady), 0);
        cyc();
        cyc();
        nRst = 1;
        smp();
        chkResetVals("rst");
        cyc();

        // Saturation on the 4-bit instance, with a 10-cycle watchdog.
        sbus.i_operationForbidden = 1;
        sbus.i_reqValid = 1; sbus.i_reqKind = 3'd0; sbus.i_reqReg = 5'd1; sbus.i_reqData = 32'hF;
        smp();
        chk("sat_ready", 32'(sbus.o_reqReady), 1);
        cyc();
        sbus.i_reqValid = 0;
        for (int i = 1; i <= 20; i++) begin
            smp();
            if (i == 10) chk("sat_terr_before", 32'(terr2), 0);
            if (i == 11) chk("sat_terr_at", 32'(terr2), 1);
            if (i == 15) chk("sat_cnt14", 32'(stall2), 14);
            if (i == 20) begin
                chk("sat_cnt_sat", 32'(stall2), 15);
                chk("sat_no_strobe", 32'(sbus.o_WritReg), 0);
            end
            cyc();
        end
        sbus.i_operationForbidden = 0;
        smp();
        chk("sat_strobe", 32'(sbus.o_WritReg), 1);
        chk("sat_cnt_hold", 32'(stall2), 15);
        cyc();

        // Single requests with the engine idle.
        for (int k = 0; k < 8; k++) begin
            req(vt[k].kind, vt[k].rg, vt[k].data, vt[k].cmd);
            bus.i_dataOut = vt[k].dout;
            smp();
            chk($sformatf("v%0d_accept", k), 32'(bus.o_reqReady), 1);
            cyc();
            bus.i_reqValid = 0;
            smp();
            chk($sformatf("v%0d_strobes", k), strobes(), 32'(vt[k].stb));
            if (vt[k].stb[2] || vt[k].stb[1]) chk($sformatf("v%0d_regID", k), 32'(bus.o_regID), 32'(vt[k].id));
            if (vt[k].stb[2]) chk($sformatf("v%0d_dataIn", k), bus.o_dataIn, vt[k].data);
            if (vt[k].stb[0]) chk($sformatf("v%0d_instr", k), 32'(bus.o_Instruction), 32'(vt[k].cmd));
            chk($sformatf("v%0d_ready_n1", k), 32'(bus.o_reqReady), 32'(vt[k].stb == 3'b000));
            cyc();
            bus.i_dataOut = ~vt[k].dout;
            smp();
            chk($sformatf("v%0d_rspValid", k), 32'(bus.o_rspValid), 32'(vt[k].rsp));
            if (vt[k].rsp) chk($sformatf("v%0d_rspData", k), bus.o_rspData, vt[k].dout);
            chk($sformatf("v%0d_ready_n2", k), 32'(bus.o_reqReady), 32'(!vt[k].rsp));
            chk($sformatf("v%0d_strobes_n2", k), strobes(), 0);
            cyc();
            if (vt[k].rsp) begin
                bus.i_rspReady = 1;
                smp();
                cyc();
                bus.i_rspReady = 0;
                smp();
                chk($sformatf("v%0d_rsp_cleared", k), 32'(bus.o_rspValid), 0);
                cyc();
            end
        end

        // CFC2 response held for 3 cycles; a competing request must be ignored.
        req(3'd3, 5'd31, 32'h0, 25'h0);
        bus.i_dataOut = 32'hDEAD_BEEF;
        smp();
        cyc();
        bus.i_reqValid = 0;
        smp();
        chk("hold_read_strobe", 32'(bus.o_ReadReg), 1);
        chk("hold_regID", 32'(bus.o_regID), 63);
        cyc();
        bus.i_dataOut = 32'h0;
        req(3'd0, 5'd2, 32'h5A5A_5A5A, 25'h0);
        for (int i = 0; i < 3; i++) begin
            smp();
            chk($sformatf("hold%0d_valid", i), 32'(bus.o_rspValid), 1);
            chk($sformatf("hold%0d_data", i), bus.o_rspData, 32'hDEAD_BEEF);
            chk($sformatf("hold%0d_ready", i), 32'(bus.o_reqReady), 0);
            cyc();
        end
        bus.i_reqValid = 0;
        bus.i_rspReady = 1;
        smp();
        cyc();
        bus.i_rspReady = 0;
        smp();
        chk("hold_released", 32'(bus.o_rspValid), 0);
        chk("hold_no_stray_strobe", strobes(), 0);
        cyc();

        // CMD then MFC2; the engine is busy from the cycle after o_run until 14 waiting cycles elapse.
        req(3'd4, 5'd0, 32'h0, 25'h0000001);
        smp();
        cyc();
        bus.i_reqValid = 0;
        smp();
        chk("cmd_run", 32'(bus.o_run), 1);
        chk("cmd_instr", 32'(bus.o_Instruction), 1);
        cyc();
        bus.i_operationForbidden = 1;
        req(3'd2, 5'd14, 32'h0, 25'h0);
        smp();
        chk("mfc_accept", 32'(bus.o_reqReady), 1);
        cyc();
        bus.i_reqValid = 0;
        for (int i = 1; i <= 14; i++) begin
            smp();
            chk($sformatf("mfc_wait%0d", i), strobes(), 0);
            cyc();
        end
        bus.i_operationForbidden = 0;
        bus.i_dataOut = 32'h5555_AAAA;
        smp();
        chk("mfc_strobe", 32'(bus.o_ReadReg), 1);
        chk("mfc_regID", 32'(bus.o_regID), 14);
        chk("mfc_stall", 32'(stall), 14);
        cyc();
        bus.i_dataOut = 32'h0;
        smp();
        chk("mfc_rspValid", 32'(bus.o_rspValid), 1);
        chk("mfc_rspData", bus.o_rspData, 32'h5555_AAAA);
        bus.i_rspReady = 1;
        cyc();
        bus.i_rspReady = 0;

        // Watchdog: engine busy for 300 cycles with a request waiting.
        bus.i_operationForbidden = 1;
        req(3'd0, 5'd2, 32'h0000_0077, 25'h0);
        smp();
        chk("to_accept", 32'(bus.o_reqReady), 1);
        cyc();
        bus.i_reqValid = 0;
        for (int i = 1; i <= 300; i++) begin
            smp();
            if (i == 255) chk("to_terr_254", 32'(terr), 0);
            if (i == 256) chk("to_terr_255", 32'(terr), 1);
            if (i == 300) begin
                chk("to_terr_sticky", 32'(terr), 1);
                chk("to_no_strobe", strobes(), 0);
            end
            cyc();
        end
        bus.i_operationForbidden = 0;
        smp();
        chk("to_strobe", 32'(bus.o_WritReg), 1);
        chk("to_regID", 32'(bus.o_regID), 2);
        chk("to_dataIn", bus.o_dataIn, 32'h77);
        chk("to_stall", 32'(stall), 314);
        cyc();
        smp();
        chk("to_terr_after", 32'(terr), 1);
        chk("to_single_strobe", strobes(), 0);
        chk("to_dataIn_held", bus.o_dataIn, 32'h77);
        cyc();

        // Reset with a response pending.
        req(3'd2, 5'd5, 32'h0, 25'h0);
        bus.i_dataOut = 32'h1111_2222;
        smp();
        cyc();
        bus.i_reqValid = 0;
        smp();
        chk("rr_read", 32'(bus.o_ReadReg), 1);
        cyc();
        nRst = 0;
        smp();
        chk("rr_ready_in_reset", 32'(bus.o_reqReady), 0);
        cyc();
        nRst = 1;
        smp();
        chkResetVals("rr");
        cyc();

        // Reset while in ISSUE, with the engine going idle in the same cycle.
        bus.i_operationForbidden = 1;
        req(3'd0, 5'd7, 32'h0000_0099, 25'h0);
        smp();
        cyc();
        bus.i_reqValid = 0;
        bus.i_operationForbidden = 0;
        nRst = 0;
        smp();
        chk("ri_no_strobe_reset", strobes(), 0);
        cyc();
        nRst = 1;
        smp();
        chk("ri_no_strobe_after", strobes(), 0);
        chk("ri_ready", 32'(bus.o_reqReady), 1);
        chk("ri_dataIn", bus.o_dataIn, 0);
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/gte_cop2_bridge.md
Name: gte_cop2_bridge

Overview:
CPU-side initiator for the GTE coprocessor. It converts CPU COP2 requests (MTC2, CTC2, MFC2, CFC2, COP2 command) into the engine's register-port and instruction-port signalling. It honours the engine's busy interlock (operationForbidden) and returns read data through a one-entry response buffer. It sits between the CPU pipeline's coprocessor port and the GTE engine, and owns stall accounting and a busy watchdog.

Parameters:
STALL_CNT_W, 16, width of the saturating stall-cycle counter.
TIMEOUT_CYC, 255, number of consecutive busy cycles while a request is waiting before o_timeoutErr is set. Legal range is 1..65535.

Ports:
i_clk  in  1  clock; the single clock domain.
i_nRst  in  1  reset; synchronous, active-low (0 = reset, 1 = working).
i_reqValid  in  1  CPU request valid.
o_reqReady  out  1  request accepted when i_reqValid & o_reqReady.
i_reqKind  in  3  request kind: 0 MTC2, 1 CTC2, 2 MFC2, 3 CFC2, 4 CMD; 5..7 reserved.
i_reqReg  in  5  COP2 register number.
i_reqData  in  32  write data (MTC2/CTC2).
i_reqCmd  in  25  instruction word (CMD).
o_rspValid  out  1  read data valid.
i_rspReady  in  1  CPU consumes the response.
o_rspData  out  32  read data.
o_regID  out  6  engine register ID.
o_WritReg  out  1  engine register write strobe.
o_ReadReg  out  1  engine register read strobe.
o_dataIn  out  32  engine write data.
i_dataOut  in  32  engine read data; zero latency, combinational from o_regID.
o_Instruction  out  25  engine instruction.
o_run  out  1  engine instruction valid.
i_operationForbidden  in  1  engine busy (executing or official timing).
o_stallCycles  out  STALL_CNT_W  saturating count of interlock cycles.
o_timeoutErr  out  1  sticky watchdog flag.

Behaviour:
- Reset values: state IDLE; o_reqReady=0 during reset; o_rspValid=0; o_rspData=0; o_WritReg, o_ReadReg and o_run =0; o_regID=0; o_dataIn=0; o_Instruction=0; o_stallCycles=0; o_timeoutErr=0.
- Reset mid-operation drops any held request and any buffered response. No strobe is issued in the reset cycle or the cycle after it.
- States:
  - IDLE: o_reqReady = !o_rspValid.
  - On accept, latch kind, reg, data and cmd into the hold registers, then go to ISSUE.
  - Reserved kinds are accepted and discarded, with no strobe and no response; the state stays IDLE.
  - ISSUE: o_reqReady=0.
    - If i_operationForbidden=1: no strobe; increment o_stallCycles (saturating at all-ones); increment the wait counter; stay in ISSUE.
    - If i_operationForbidden=0: assert exactly one strobe this cycle.
      - MTC2: o_WritReg=1, o_regID = {1'b0, reg}.
      - CTC2: o_WritReg=1, o_regID = {1'b1, reg}.
      - MFC2/CFC2: o_ReadReg=1 with the same ID mapping; capture i_dataOut into o_rspData at the clock edge; set o_rspValid on the next cycle.
      - CMD: o_run=1, o_Instruction = cmd.
    - Then return to IDLE and clear the wait counter.
- Strobes are single-cycle. o_regID, o_dataIn and o_Instruction hold their last values when no strobe is active.
- Latency:
  - Accept at cycle N: earliest strobe at N+1.
  - Read data: o_rspValid at N+2.
  - Next accept: earliest at N+2, provided no response is pending.
- Response buffer:
  - o_rspValid holds, with o_rspData stable, until i_rspReady.
  - o_rspValid clears on the cycle after the handshake.
  - A new request is not accepted while o_rspValid=1. This preserves in-order reads.
- Back-to-back CMD: the engine raises operationForbidden one cycle after o_run. The bridge needs no extra guard because ISSUE is never entered in the cycle directly after a strobe.
- Watchdog: when the wait counter reaches TIMEOUT_CYC, o_timeoutErr=1. It stays set until reset. The request keeps waiting and is never dropped.
- Simultaneous events:
  - Forbidden falling in the same cycle the bridge sits in ISSUE issues the strobe that cycle.
  - The counter at saturation stays saturated.
  - i_reqValid during ISSUE is ignored, because ready=0.

Decomposition:
- Package gte_bridge_pkg holds:
  - enum E_COP2KIND for the kind codes;
  - enum E_BRIDGE_ST {IDLE, ISSUE};
  - the constant for the ctrl-bank offset (bit 5 of regID).
- o_regID is declared with E_REG from GTEDefine.hv.
- One small sub-module is natural: gte_bridge_rspbuf (one-entry valid/ready holding register). Everything else stays flat.

Test Plan:
- MTC2 reg 9 with data 0x00001234, forbidden=0 -> o_WritReg pulse at N+1, o_regID=9, o_dataIn=0x1234, o_reqReady back high at N+2.
- CFC2 reg 31 with i_dataOut=0xDEADBEEF -> o_ReadReg at N+1 with o_regID=63; o_rspValid at N+2 with 0xDEADBEEF; i_rspReady held 0 for 3 cycles -> data stable throughout and o_reqReady=0.
- CMD 0x0000001 (RTPS) followed by MFC2 reg 14, with the engine model forbidden for 14 cycles after o_run -> MFC2 strobe delayed exactly until forbidden=0; o_stallCycles=14 (assuming the MFC2 is accepted as soon as possible).
- Forbidden held 1 for 300 cycles with TIMEOUT_CYC=255 -> o_timeoutErr rises after 255 wait cycles and stays 1; the request issues when forbidden drops.
- Reset asserted while in ISSUE with a pending response -> no strobe issued and all outputs at reset values the following cycle; a reserved kind of 6 -> accepted, with no strobe and no response.
- Saturation with STALL_CNT_W=4 and forbidden held for 20 cycles -> o_stallCycles=15.
